i2c_target_mem: RTL
===================

# i2c_target_mem

Parametrised I2C target (slave) emulating a byte-addressed EEPROM/register bank, successor to the single-shot debug sink used on the ZUBoard MAC-EEPROM bus. It synchronises and filters SCL/SDA, decodes START/STOP/repeated-START and matches a configurable 7-bit device address, NACKing foreign addresses. It supports 1- or 2-byte memory addressing and multi-byte sequential writes/reads with pointer auto-increment and wrap. It sits between the PS I2C tri-state pins and fabric logic, which sees a second memory port and per-byte write strobes.

## Interface
- DEV_ADDR, 7'h58, 7-bit target address
- ADDR_BYTES, 1, memory-address bytes sent by the controller (1 or 2, big-endian)
- DEPTH, 256, memory bytes (power of 2, 2..65536); AW = $clog2(DEPTH)
- FILT_LEN, 4, clk cycles a synchronised level must be stable to be accepted
- HOLD_CYC, 30, clk cycles after accepted SCL fall before SDA may change
- clk  in  1  fabric clock, 100 MHz; one clock; reset is synchronous and active-high
- rst  in  1  synchronous, active-high reset
- scl_i  in  1  bus SCL (asynchronous)
- sda_i  in  1  bus SDA (asynchronous)
- sda_o  out  1  constant 0 (open-drain)
- sda_t  out  1  tri-state: 1 = release, 0 = drive low; reset 1
- usr_we  in  1  fabric write enable
- usr_addr  in  AW  fabric address
- usr_wdata  in  8  fabric write data
- usr_rdata  out  8  mem[usr_addr], 1-cycle latency; reset 0
- wr_strb  out  1  1-cycle pulse per bus-written byte; reset 0
- wr_addr  out  AW  address of that byte; reset 0
- wr_data  out  8  data of that byte; reset 0
- usr_collision  out  1  pulse: usr_we dropped due to same-cycle bus write; reset 0
- busy  out  1  1 from accepted START with address match to STOP; reset 0

## Operation
- Input path: 2-FF sync, then filter (level accepted after FILT_LEN equal samples), then rise/fall edge detect on filtered scl/sda.
- START = filtered SDA fall while SCL high; STOP = SDA rise while SCL high. START in any state (repeated START) -> DADDR, bit count 7; STOP in any state -> IDLE, sda_t=1, busy=0.
- Bits sampled on SCL rise, MSB first.
- States: IDLE, DADDR, DACK, MADDR, MACK, WDATA, WACK, RDATA, RACK, IGNORE.
- DADDR: 8 bits; bits[7:1]==DEV_ADDR -> DACK (ACK), rw = bit0; else IGNORE (SDA released, wait for START/STOP).
- DACK then: rw=0 -> MADDR; rw=1 -> RDATA, byte loaded from mem[ptr].
- MADDR: ADDR_BYTES bytes each followed by MACK; ptr = address mod DEPTH (high bits discarded). Then WDATA.
- WDATA/WACK: each byte ACKed; on WACK SCL rise write mem[ptr], pulse wr_strb with wr_addr=ptr, ptr = ptr+1 mod DEPTH.
- RDATA: drive bits on SDA (0 -> sda_t=0, 1 -> release); after 8th bit release, go RACK, ptr+1 mod DEPTH. RACK samples controller ACK on SCL rise: 0 -> load mem[ptr], RDATA; 1 (NACK) -> IGNORE.
- ptr persists across transactions (current-address read); reset to 0.
- Memory: DEPTH x 8, not cleared by reset. Bus and usr writes to any address in same cycle: bus wins, usr write dropped, usr_collision pulses. Bus read and usr read never conflict.

## Timing
- Input latency to edge detect: 2 + FILT_LEN clk.
- All SDA changes (ACK assert, data bit, release) occur exactly HOLD_CYC clk after accepted SCL fall; ACK held until HOLD_CYC after the following SCL fall.
- wr_strb asserted 1 clk after WACK SCL-rise detect.
- rst mid-transfer: next clk sda_t=1, state IDLE, busy=0, ptr=0; memory kept; next bus activity ignored until a fresh START.
- Supports SCL up to 400 kHz at clk 100 MHz with defaults.

## Structure
- Package i2c_target_pkg: state enum i2c_tgt_state_t, START/STOP event type, ADDR_BYTES range constants.
- Sub-module i2c_line_filt: sync + glitch filter + edge detect, instantiated once per line (SCL, SDA).
- Memory inferred as simple dual-port RAM in the top.

## Test plan
- Write 0x58/W, addr 0x10, data 0xA1 0xB2 0xC3 -> all ACKed, wr_strb x3 at 0x10..0x12; usr_rdata at 0x11 = 0xB2.
- Address 0x50 -> 9th-bit SDA high (NACK), no wr_strb, busy stays 0.
- Write at addr 0xFF bytes 0x11 0x22 (DEPTH=256) -> mem[0xFF]=0x11, mem[0x00]=0x22.
- Random read: W addr 0x10, repeated START, R 3 bytes, controller NACK last -> SDA shows 0xA1 0xB2 0xC3, SDA released after NACK.
- usr_we to 0x20=0x55 in same clk as bus write to 0x30 -> mem[0x30] bus value, mem[0x20] unchanged, usr_collision=1 for one clk.
- rst asserted mid-RDATA with SDA low -> sda_t=1 next clk; subsequent START + read from 0x00 works.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// Shared types for the I2C target memory: FSM states, bus events and
// the supported range of memory-address bytes.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DADDR,
    ST_DACK,
    ST_MADDR,
    ST_MACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } i2c_tgt_state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_START,
    EV_STOP
  } i2c_bus_ev_t;

  localparam int ADDR_BYTES_MIN = 1;
  localparam int ADDR_BYTES_MAX = 2;

  // SDA moving while SCL is high is a bus condition, never data.
  function automatic i2c_bus_ev_t bus_event(input logic scl_lvl,
                                            input logic sda_rise,
                                            input logic sda_fall);
    if (scl_lvl && sda_rise) return EV_STOP;
    if (scl_lvl && sda_fall) return EV_START;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/i2c_line_filt.sv
// One bus line: two-flop synchroniser, stability filter and edge detect
// on the accepted level. Idle bus level is high, so everything resets to 1.
module i2c_line_filt #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          lvl_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      lvl     <= 1'b1;
      lvl_q   <= 1'b1;
      cnt     <= '0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      lvl_q   <= lvl;
      // A new level is taken only after FILT_LEN consecutive agreeing samples.
      if (sync_p1 == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        lvl <= sync_p1;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target emulating a byte-addressed EEPROM, with a second fabric port
// into the same memory and a per-byte strobe for every bus-written byte.
module i2c_target_mem
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h58,
  parameter int         ADDR_BYTES = 1,
  parameter int         DEPTH      = 256,
  parameter int         FILT_LEN   = 4,
  parameter int         HOLD_CYC   = 30,
  localparam int        AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_o,
  output logic          sda_t,
  input  logic          usr_we,
  input  logic [AW-1:0] usr_addr,
  input  logic [7:0]    usr_wdata,
  output logic [7:0]    usr_rdata,
  output logic          wr_strb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          usr_collision,
  output logic          busy
);

  localparam int AB = (ADDR_BYTES < ADDR_BYTES_MIN) ? ADDR_BYTES_MIN :
                      (ADDR_BYTES > ADDR_BYTES_MAX) ? ADDR_BYTES_MAX : ADDR_BYTES;
  localparam int HW = $clog2(HOLD_CYC + 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filt #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk (clk),
    .rst (rst),
    .din (scl_i),
    .lvl (scl_lvl),
    .rise(scl_rise),
    .fall(scl_fall)
  );

  i2c_line_filt #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk (clk),
    .rst (rst),
    .din (sda_i),
    .lvl (sda_lvl),
    .rise(sda_rise),
    .fall(sda_fall)
  );

  i2c_bus_ev_t    ev;
  i2c_tgt_state_t state;
  logic [2:0]     bit_cnt;
  logic [7:0]     rx;
  logic [7:0]     tx;
  logic [15:0]    maddr;
  logic           addr_idx;
  logic           rw;
  logic [AW-1:0]  ptr;
  logic [HW-1:0]  hold_cnt;
  logic           sda_nxt;
  logic [7:0]     rd_q;
  logic [7:0]     mem [DEPTH];

  assign ev    = bus_event(scl_lvl, sda_rise, sda_fall);
  assign sda_o = 1'b0;

  always_ff @(posedge clk) begin
    wr_strb <= 1'b0;
    if (rst) begin
      state    <= ST_IDLE;
      sda_t    <= 1'b1;
      sda_nxt  <= 1'b1;
      busy     <= 1'b0;
      ptr      <= '0;
      bit_cnt  <= '0;
      rx       <= '0;
      tx       <= '0;
      maddr    <= '0;
      addr_idx <= 1'b0;
      rw       <= 1'b0;
      hold_cnt <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      // SDA only ever moves when the hold timer started at an SCL fall expires.
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
        if (hold_cnt == HW'(1)) sda_t <= sda_nxt;
      end
      case (ev)
        EV_STOP: begin
          state    <= ST_IDLE;
          sda_t    <= 1'b1;
          busy     <= 1'b0;
          hold_cnt <= '0;
        end
        EV_START: begin
          state    <= ST_DADDR;
          bit_cnt  <= '0;
          rx       <= '0;
          maddr    <= '0;
          addr_idx <= 1'b0;
          sda_t    <= 1'b1;
          hold_cnt <= '0;
        end
        default: begin
          if (scl_rise) begin
            case (state)
              ST_DADDR: begin
                rx      <= {rx[6:0], sda_lvl};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  if (rx[6:0] == DEV_ADDR) begin
                    state <= ST_DACK;
                    rw    <= sda_lvl;
                    busy  <= 1'b1;
                  end else begin
                    state <= ST_IGNORE;
                  end
                end
              end
              ST_DACK: begin
                bit_cnt <= '0;
                if (rw) begin
                  state <= ST_RDATA;
                  tx    <= rd_q;
                end else begin
                  state <= ST_MADDR;
                end
              end
              ST_MADDR: begin
                rx      <= {rx[6:0], sda_lvl};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  maddr <= {maddr[7:0], rx[6:0], sda_lvl};
                  state <= ST_MACK;
                end
              end
              ST_MACK: begin
                // Address is big-endian; bits above AW are discarded.
                if (addr_idx == 1'(AB - 1)) begin
                  ptr   <= maddr[AW-1:0];
                  state <= ST_WDATA;
                end else begin
                  addr_idx <= addr_idx + 1'b1;
                  state    <= ST_MADDR;
                end
              end
              ST_WDATA: begin
                rx      <= {rx[6:0], sda_lvl};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state <= ST_WACK;
              end
              ST_WACK: begin
                wr_strb <= 1'b1;
                wr_addr <= ptr;
                wr_data <= rx;
                ptr     <= ptr + AW'(1);
                state   <= ST_WDATA;
              end
              ST_RDATA: begin
                tx      <= {tx[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  state <= ST_RACK;
                  ptr   <= ptr + AW'(1);
                end
              end
              ST_RACK: begin
                if (!sda_lvl) begin
                  tx    <= rd_q;
                  state <= ST_RDATA;
                end else begin
                  state <= ST_IGNORE;
                end
              end
              default: ;
            endcase
          end else if (scl_fall) begin
            hold_cnt <= HW'(HOLD_CYC);
            case (state)
              ST_DACK, ST_MACK, ST_WACK: sda_nxt <= 1'b0;
              ST_RDATA:                  sda_nxt <= tx[7];
              default:                   sda_nxt <= 1'b1;
            endcase
          end
        end
      endcase
    end
  end

  // Single write port shared by bus and fabric; the bus always wins.
  always_ff @(posedge clk) begin
    if (wr_strb) begin
      mem[wr_addr] <= wr_data;
    end else if (usr_we) begin
      mem[usr_addr] <= usr_wdata;
    end
    rd_q <= mem[ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      usr_rdata     <= '0;
      usr_collision <= 1'b0;
    end else begin
      usr_rdata     <= mem[usr_addr];
      usr_collision <= usr_we & wr_strb;
    end
  end

endmodule
